mac_pe_nch: RTL

Next-generation systolic processing element. Accepts activations on NCH channels (lowest valid index wins), multiplies by a locally stored weight, and accumulates over a programmable dot-product length K. Each completed result goes into an output holding register with a valid/ready handshake. Activations and their valids pass through to the neighbouring PE one cycle later, as in the existing array fabric.

---
 rtl/mac_pkg.sv | 25 ++
 rtl/mac_chan_sel.sv | 23 ++
 rtl/mac_pe_nch.sv | 115 +++++++++++
 3 files changed

// File: rtl/mac_pkg.sv
// mac_pkg: FSM state, width/slice helpers and the accumulator add for mac_pe_nch.
// The add wraps by default and saturates when MAC_PE_SAT_EN is defined.
package mac_pkg;
  typedef enum logic {IDLE, ACCUM} state_e;
  function automatic int prod_w(input int w);
    return 2 * w;
  endfunction
  function automatic int chan_lo(input int c, input int w);
    return c * w;
  endfunction
  function automatic logic signed [63:0] sat_add(input logic signed [63:0] a, input logic signed [63:0] b,
                                                 input int acc_w);
    logic signed [63:0] s;
`ifdef MAC_PE_SAT_EN
    logic signed [63:0] hi, lo;
    s = a + b;
    hi = (64'sd1 <<< (acc_w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    return (s > hi) ? hi : (s < lo) ? lo : s;
`else
    s = a + b;
    return (s <<< (64 - acc_w)) >>> (64 - acc_w);
`endif
  endfunction
endpackage

// File: rtl/mac_chan_sel.sv
// mac_chan_sel: priority encoder picking the lowest-index valid channel and its activation.
module mac_chan_sel
  import mac_pkg::*;
#(
  parameter int W     = 8,
  parameter int NCH   = 3,
  parameter int IDX_W = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic [NCH-1:0]          valid_i,
  input  logic [NCH*W-1:0]        a_i,
  output logic [IDX_W-1:0]        idx_o,
  output logic signed [W-1:0]     act_o
);
  always_comb begin
    idx_o = '0;
    act_o = a_i[W-1:0];
    for (int c = NCH - 1; c >= 0; c--)
      if (valid_i[c]) begin
        idx_o = IDX_W'(c);
        act_o = a_i[chan_lo(c, W) +: W];
      end
  end
endmodule

// File: rtl/mac_pe_nch.sv
// mac_pe_nch: systolic MAC PE, NCH activation channels, K-length dot products, valid/ready result.
// Define MAC_PE_SAT_EN for a saturating accumulator and the sticky sat_flag output.
module mac_pe_nch
  import mac_pkg::*;
#(
  parameter int W     = 8,
  parameter int ACC_W = 24,
  parameter int NCH   = 3,
  parameter int K_W   = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    weight_load,
  input  logic signed [W-1:0]     weight_in,
  input  logic [K_W-1:0]          k_len,
  input  logic [NCH-1:0]          valid_in,
  input  logic [NCH*W-1:0]        a_in,
  output logic                    in_ready,
  output logic [NCH*W-1:0]        a_out,
  output logic [NCH-1:0]          valid_out_fwd,
  output logic signed [ACC_W-1:0] acc_out,
  output logic                    acc_valid,
  input  logic                    acc_ready
`ifdef MAC_PE_SAT_EN
  , output logic                  sat_flag
`endif
);
  localparam int PW    = prod_w(W);
  localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;
  logic signed [W-1:0]     weight_q, act;
  logic [IDX_W-1:0]        idx;
  logic signed [PW-1:0]    s1_prod_q;
  logic                    s1_valid_q, s1_last_q, acc_valid_q;
  logic signed [ACC_W-1:0] acc_q, acc_out_q, sum;
  logic signed [63:0]      sum64;
  logic [NCH*W-1:0]        a_out_q;
  logic [NCH-1:0]          vfwd_q;
  logic [K_W-1:0]          count_q, k_q, k_eff, k_cur;
  state_e                  state_q;
  logic                    stall, accept, last, done;
  mac_chan_sel #(.W(W), .NCH(NCH), .IDX_W(IDX_W)) u_sel (
    .valid_i(valid_in), .a_i(a_in), .idx_o(idx), .act_o(act)
  );
  always_comb begin
    stall  = s1_valid_q & s1_last_q & acc_valid_q & ~acc_ready;
    accept = ~stall & ~clear & valid_in[idx];
    k_eff  = (k_len == '0) ? K_W'(1) : k_len;
    k_cur  = (state_q == IDLE) ? k_eff : k_q;
    last   = count_q == k_cur - K_W'(1);
    done   = ~clear & s1_valid_q & s1_last_q & ~stall;
    sum64  = sat_add(64'(acc_q), 64'(ACC_W'(s1_prod_q)), ACC_W);
    sum    = sum64[ACC_W-1:0];
  end
  assign in_ready      = ~stall;
  assign a_out         = a_out_q;
  assign valid_out_fwd = vfwd_q;
  assign acc_out       = acc_out_q;
  assign acc_valid     = acc_valid_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      weight_q    <= '0;
      a_out_q     <= '0;
      vfwd_q      <= '0;
      s1_prod_q   <= '0;
      s1_valid_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      acc_q       <= '0;
      acc_out_q   <= '0;
      acc_valid_q <= 1'b0;
      count_q     <= '0;
      k_q         <= '0;
      state_q     <= IDLE;
    end else begin
      a_out_q <= a_in;
      vfwd_q  <= valid_in;
      if (weight_load) weight_q <= weight_in;
      if (clear) begin
        acc_q      <= '0;
        count_q    <= '0;
        state_q    <= IDLE;
        s1_valid_q <= 1'b0;
      end else begin
        if (accept) begin
          s1_prod_q <= PW'(act) * PW'(weight_q);
          s1_last_q <= last;
          if (state_q == IDLE) k_q <= k_eff;
          count_q <= last ? '0 : count_q + K_W'(1);
          state_q <= last ? IDLE : ACCUM;
        end
        if (!stall) s1_valid_q <= accept;
        if (s1_valid_q && !stall) acc_q <= s1_last_q ? '0 : sum;
      end
      if (done) begin
        acc_out_q   <= sum;
        acc_valid_q <= 1'b1;
      end else if (acc_valid_q && acc_ready) acc_valid_q <= 1'b0;
    end
  end
`ifdef MAC_PE_SAT_EN
  logic sat_acc_q, sat_q, sat_now;
  assign sat_now  = sum64 != 64'(acc_q) + 64'(ACC_W'(s1_prod_q));
  assign sat_flag = sat_q;
  // Running flag covers the dot product in flight; sat_q tracks the result on acc_out.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      sat_acc_q <= 1'b0;
      sat_q     <= 1'b0;
    end else if (s1_valid_q && !stall) begin
      sat_acc_q <= s1_last_q ? 1'b0 : sat_acc_q | sat_now;
      if (s1_last_q) sat_q <= sat_acc_q | sat_now;
    end else if (acc_valid_q && acc_ready) sat_q <= 1'b0;
  end
`endif
endmodule
